// File: rtl/multiplier_pkg.sv
// Shared mode encodings, FSM state type and lane geometry for the multiplier
// result accumulator.
package multiplier_pkg;

  localparam logic [1:0] MODE_27X27   = 2'd0;
  localparam logic [1:0] MODE_SUM_9X9 = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned NUM_LANES      = 3;
  localparam int unsigned LANE_PITCH     = 18;
  localparam int unsigned LANE_SUM_W     = 20;
  localparam int unsigned RESULT_W       = 54;
  localparam int unsigned CARRY_W        = 6;
  localparam int unsigned S1_W           = NUM_LANES * LANE_SUM_W;
  localparam int unsigned OUT_W          = 72;
  localparam int unsigned OUT_LANE_PITCH = 24;

endpackage

// File: rtl/multiplier_result_accumulator_lane_accumulator.sv
// One 9x9-mode lane accumulator: extends the 20-bit lane sum and accumulates it.
// Saturating when MULTIPLIER_RESULT_ACC_SATURATE_EN is defined, modulo wrap otherwise.
module lane_accumulator
  import multiplier_pkg::*;
#(
  parameter int unsigned LANE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic                  signed_i,
  input  logic [LANE_SUM_W-1:0] term_i,
  output logic [LANE_W-1:0]     acc_o
);

  logic [LANE_W-1:0] acc_q, acc_d, term_ext, acc_sum;

  assign term_ext = {{(LANE_W-LANE_SUM_W){signed_i & term_i[LANE_SUM_W-1]}}, term_i};

`ifdef MULTIPLIER_RESULT_ACC_SATURATE_EN
  logic [LANE_W:0] sum_wide;

  // One guard bit: signed overflow when it disagrees with the sign bit,
  // unsigned overflow when it is a carry out.
  assign sum_wide = {signed_i & acc_q[LANE_W-1], acc_q}
                  + {signed_i & term_ext[LANE_W-1], term_ext};

  always_comb begin
    acc_sum = sum_wide[LANE_W-1:0];
    if (signed_i) begin
      if (sum_wide[LANE_W] != sum_wide[LANE_W-1])
        acc_sum = {sum_wide[LANE_W], {(LANE_W-1){~sum_wide[LANE_W]}}};
    end else if (sum_wide[LANE_W]) begin
      acc_sum = '1;
    end
  end
`else
  assign acc_sum = acc_q + term_ext;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = load_i ? term_ext : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/multiplier_result_accumulator.sv
// Two-stage accumulator for 27x27 / sum-of-three-9x9 multiplier partial sums,
// with IDLE/ACCUM/HOLD group control. Optional MULTIPLIER_RESULT_ACC_SATURATE_EN.
module multiplier_result_accumulator
  import multiplier_pkg::*;
#(
  parameter int unsigned LANE_W = 24,
  parameter int unsigned WIDE_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [1:0]                 mode,
  input  logic                       a_sign,
  input  logic                       b_sign,
  input  logic signed [RESULT_W-1:0] result_0,
  input  logic signed [RESULT_W-1:0] result_1,
  input  logic [CARRY_W-1:0]         result_SIMD_carry,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [1:0]                 out_mode
);

  state_e            state_q, state_d;
  logic              s1_valid_q, s1_last_q, s1_first_q;
  logic [S1_W-1:0]   s1_data_q, s1_data_d;
  logic [1:0]        mode_q;
  logic              signed_q;
  logic [WIDE_W-1:0] wide_q, wide_d, wide_term, wide_sum;
  logic [LANE_W-1:0] lane_acc [NUM_LANES];
  logic              accept, eff_sum9, grp_sum9, release_grp;

  assign in_ready    = !reset && (state_q != HOLD) && !(s1_valid_q && s1_last_q);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == HOLD);
  assign release_grp = out_valid && out_ready;
  assign out_mode    = mode_q;
  assign grp_sum9    = (mode_q == MODE_SUM_9X9);
  // The first beat is combined before mode_q is latched, so it uses the live input.
  assign eff_sum9    = ((state_q == IDLE) ? mode : mode_q) == MODE_SUM_9X9;

  always_comb begin
    s1_data_d = '0;
    if (eff_sum9) begin
      for (int unsigned i = 0; i < NUM_LANES; i++)
        s1_data_d[LANE_SUM_W*i +: LANE_SUM_W] =
          {result_SIMD_carry[2*i +: 2], result_0[LANE_PITCH*i +: LANE_PITCH]}
          + {2'b00, result_1[LANE_PITCH*i +: LANE_PITCH]};
    end else begin
      s1_data_d[RESULT_W-1:0] = result_0 + result_1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (s1_valid_q && s1_last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_data_q  <= '0;
      mode_q     <= MODE_27X27;
      signed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q  <= in_last;
        s1_first_q <= (state_q == IDLE);
        s1_data_q  <= s1_data_d;
      end
      if (accept && state_q == IDLE) begin
        mode_q   <= mode;
        signed_q <= a_sign | b_sign;
      end
    end
  end

  assign wide_term = {{(WIDE_W-RESULT_W){signed_q & s1_data_q[RESULT_W-1]}},
                      s1_data_q[RESULT_W-1:0]};

`ifdef MULTIPLIER_RESULT_ACC_SATURATE_EN
  logic [WIDE_W:0] wide_ext_sum;

  assign wide_ext_sum = {signed_q & wide_q[WIDE_W-1], wide_q}
                      + {signed_q & wide_term[WIDE_W-1], wide_term};

  always_comb begin
    wide_sum = wide_ext_sum[WIDE_W-1:0];
    if (signed_q) begin
      if (wide_ext_sum[WIDE_W] != wide_ext_sum[WIDE_W-1])
        wide_sum = {wide_ext_sum[WIDE_W], {(WIDE_W-1){~wide_ext_sum[WIDE_W]}}};
    end else if (wide_ext_sum[WIDE_W]) begin
      wide_sum = '1;
    end
  end
`else
  assign wide_sum = wide_q + wide_term;
`endif

  always_comb begin
    wide_d = wide_q;
    if (release_grp)
      wide_d = '0;
    else if (s1_valid_q && !grp_sum9)
      wide_d = s1_first_q ? wide_term : wide_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) wide_q <= '0;
    else       wide_q <= wide_d;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_accumulator #(
      .LANE_W(LANE_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (release_grp),
      .en_i    (s1_valid_q && grp_sum9),
      .load_i  (s1_first_q),
      .signed_i(signed_q),
      .term_i  (s1_data_q[LANE_SUM_W*g +: LANE_SUM_W]),
      .acc_o   (lane_acc[g])
    );
  end

  always_comb begin
    out_data = '0;
    if (grp_sum9) begin
      for (int unsigned i = 0; i < NUM_LANES; i++)
        out_data[OUT_LANE_PITCH*i +: LANE_W] = lane_acc[i];
    end else begin
      out_data[WIDE_W-1:0] = wide_q;
    end
  end

endmodule

// File: tb/tb_multiplier_result_accumulator.sv
// Scoreboard bench for multiplier_result_accumulator: directed corner groups plus
// random groups checked against an arithmetic reference model.
module tb_multiplier_result_accumulator;

  typedef struct {
    logic [1:0]  mode;
    bit          as;
    bit          bs;
    logic [53:0] r0;
    logic [53:0] r1;
    logic [5:0]  c;
    bit          last;
  } beat_t;

  typedef struct {
    logic [71:0] data;
    logic [1:0]  mode;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_last = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               a_sign = 1'b0;
  logic               b_sign = 1'b0;
  logic signed [53:0] result_0 = '0;
  logic signed [53:0] result_1 = '0;
  logic [5:0]         result_SIMD_carry = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [71:0]        out_data;
  logic [1:0]         out_mode;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  bit   rdy_force = 1'b1;
  bit   rdy_val = 1'b0;

  multiplier_result_accumulator #(
    .LANE_W(24),
    .WIDE_W(64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_last          (in_last),
    .mode             (mode),
    .a_sign           (a_sign),
    .b_sign           (b_sign),
    .result_0         (result_0),
    .result_1         (result_1),
    .result_SIMD_carry(result_SIMD_carry),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_mode         (out_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic on each group.
  function automatic logic [71:0] ref_model(input beat_t g[$]);
    bit          sg = g[0].as | g[0].bs;
    logic [71:0] res = '0;
    if (g[0].mode == 2'd1) begin
      for (int l = 0; l < 3; l++) begin
        longint acc = 0;
        foreach (g[k]) begin
          longint t;
          t = (longint'((g[k].c >> (2*l)) & 6'h3) << 18)
            + longint'((g[k].r0 >> (18*l)) & 54'h3FFFF)
            + longint'((g[k].r1 >> (18*l)) & 54'h3FFFF);
          t = t % 1048576;
          if (sg && t >= 524288) t = t - 1048576;
          acc = acc + t;
`ifdef MULTIPLIER_RESULT_ACC_SATURATE_EN
          if (sg) begin
            if (acc > 8388607) acc = 8388607;
            if (acc < -8388608) acc = -8388608;
          end else if (acc > 16777215) begin
            acc = 16777215;
          end
`else
          acc = acc & longint'(24'hFFFFFF);
`endif
        end
        res[24*l +: 24] = acc[23:0];
      end
    end else begin
      logic signed [71:0] acc = '0;
      foreach (g[k]) begin
        logic [53:0]        s;
        logic signed [71:0] t;
        s = g[k].r0 + g[k].r1;
        if (sg) t = $signed(s);
        else    t = {18'b0, s};
        acc = acc + t;
`ifdef MULTIPLIER_RESULT_ACC_SATURATE_EN
        if (sg) begin
          if (acc > 72'sh007FFF_FFFF_FFFF_FFFF) acc = 72'sh007FFF_FFFF_FFFF_FFFF;
          if (acc < -72'sh008000_0000_0000_0000) acc = -72'sh008000_0000_0000_0000;
        end else if (acc > 72'sh00FFFF_FFFF_FFFF_FFFF) begin
          acc = 72'sh00FFFF_FFFF_FFFF_FFFF;
        end
`else
        acc[71:64] = '0;
`endif
      end
      res = {8'b0, acc[63:0]};
    end
    return res;
  endfunction

  function automatic beat_t mk(input logic [1:0] m, input bit as, input bit bs,
                               input logic [53:0] r0, input logic [53:0] r1,
                               input logic [5:0] c, input bit last);
    beat_t b;
    b.mode = m; b.as = as; b.bs = bs; b.r0 = r0; b.r1 = r1; b.c = c; b.last = last;
    return b;
  endfunction

  function automatic beat_t rnd_beat(input bit last);
    logic [63:0] x0, x1;
    x0 = {$urandom(), $urandom()};
    x1 = {$urandom(), $urandom()};
    return mk(2'($urandom_range(0, 1)), 1'($urandom()), 1'($urandom()),
              x0[53:0], x1[53:0], 6'($urandom()), last);
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_beat(input beat_t b);
    bit ok = 1'b0;
    mode = b.mode; a_sign = b.as; b_sign = b.bs;
    result_0 = b.r0; result_1 = b.r1; result_SIMD_carry = b.c;
    in_last = b.last; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("beat_accepted", 72'(ok), 72'd1);
  endtask

  task automatic send_group(input beat_t g[$], input bit use_exp,
                            input logic [71:0] exp_data, input bit gaps);
    exp_t e;
    foreach (g[k]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(g[k]);
      if (g[k].last) begin
        e.data = use_exp ? exp_data : ref_model(g);
        e.mode = g[0].mode;
        sb.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_output", 72'(out_valid), 72'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_mode", 72'(out_mode), 72'(e.mode));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

  initial begin
    beat_t g[$];

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 72'(in_ready), 72'd0);
    chk("reset_out_valid", 72'(out_valid), 72'd0);
    chk("reset_out_data", out_data, 72'd0);
    chk("reset_out_mode", 72'(out_mode), 72'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1;

    // Unsigned single beat 1000+24, result held with out_ready low.
    g = {mk(2'd0, 0, 0, 54'd1000, 54'd24, 6'd0, 1)};
    send_group(g, 1, 72'd1024, 0);
    chk("latency_cycle1_valid", 72'(out_valid), 72'd0);
    @(posedge clk); #1;
    chk("latency_cycle2_valid", 72'(out_valid), 72'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", 72'(in_ready), 72'd0);
      chk("hold_out_valid", 72'(out_valid), 72'd1);
      chk("hold_out_data", out_data, 72'd1024);
      @(posedge clk); #1;
    end
    rdy_val = 1'b1;
    @(posedge clk); #1;
    chk("after_handshake_valid", 72'(out_valid), 72'd0);
    chk("after_handshake_in_ready", 72'(in_ready), 72'd1);
    chk("after_handshake_sb_empty", 72'(sb.size()), 72'd0);
    rdy_force = 1'b0;

    // Signed, three beats each -5.
    g = {mk(2'd0, 1, 0, -54'sd10, 54'd5, 6'd0, 0),
         mk(2'd0, 0, 0, -54'sd10, 54'd5, 6'd0, 0),
         mk(2'd1, 0, 0, -54'sd10, 54'd5, 6'd0, 1)};
    send_group(g, 1, 72'h00_FFFF_FFFF_FFFF_FFF1, 1);

    // 9x9 lane 0 carry into bit 18.
    g = {mk(2'd1, 0, 0, 54'd0, 54'd5, 6'b000001, 1)};
    send_group(g, 1, 72'h40005, 1);

    // Signed lane 0 pushed past +2^23: 17 terms of 0x7FFFF.
    g.delete();
    for (int i = 0; i < 17; i++)
      g.push_back(mk(2'd1, 0, 1, 54'h3FFFF, 54'd0, 6'b000001, i == 16));
`ifdef MULTIPLIER_RESULT_ACC_SATURATE_EN
    send_group(g, 1, 72'h7FFFFF, 0);
`else
    send_group(g, 1, 72'h87FFEF, 0);
`endif

    // Reset after two beats of a four-beat group.
    repeat (40) begin @(posedge clk); #1; end
    drive_beat(mk(2'd0, 0, 0, 54'd111, 54'd222, 6'd0, 0));
    drive_beat(mk(2'd0, 0, 0, 54'd333, 54'd444, 6'd0, 0));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_in_ready", 72'(in_ready), 72'd0);
      chk("midreset_out_valid", 72'(out_valid), 72'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_midreset_out_valid", 72'(out_valid), 72'd0);
      @(posedge clk); #1;
    end
    g = {mk(2'd0, 0, 0, 54'd7, 54'd8, 6'd0, 1)};
    send_group(g, 1, 72'd15, 0);

    // Random groups; later beats carry random mode/sign which must be ignored.
    for (int n = 0; n < 30; n++) begin
      int len = $urandom_range(1, 5);
      g.delete();
      for (int k = 0; k < len; k++) g.push_back(rnd_beat(k == len - 1));
      send_group(g, 0, '0, 1);
    end

    for (int n = 0; n < 1000 && sb.size() != 0; n++) @(posedge clk);
    chk("scoreboard_drained", 72'(sb.size()), 72'd0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
